// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - serve/rally/score match sequencer with synchronized start switch
// Optional build macro MATCH_WIN_BY_TWO_EN selects the win-by-two rule with a cap win at 15.
module match_sequencer #(
  parameter int WIN_SCORE   = 10,
  parameter int SERVE_TICKS = 64
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       point_left,
  input  logic       point_right,
  output logic [1:0] state,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       ball_run,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);
  localparam logic [3:0] WIN_4      = 4'(WIN_SCORE);

  state_t     cur_state, nxt_state;
  logic [7:0] serve_cnt, nxt_cnt;
  logic [3:0] nxt_left, nxt_right;
  logic       nxt_dir, nxt_winner;

  logic       start_meta, start_sync, start_prev;
  logic [1:0] sync_fill;
  logic       start_armed;
  logic       start_rise, start_low;

  logic [3:0] left_inc, right_inc;
  logic       left_win, right_win;

  // A rise only counts once a genuine synchronized low has been seen after reset,
  // so a switch left high across reset release cannot launch a match.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      start_meta  <= 1'b0;
      start_sync  <= 1'b0;
      start_prev  <= 1'b0;
      sync_fill   <= 2'b00;
      start_armed <= 1'b0;
    end else begin
      start_meta <= start;
      start_sync <= start_meta;
      start_prev <= start_sync;
      sync_fill  <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && !start_sync)
        start_armed <= 1'b1;
    end
  end

  assign start_rise = start_sync & ~start_prev & start_armed;
  assign start_low  = ~start_sync;

  assign left_inc  = (left_score == 4'd15) ? 4'd15 : left_score + 4'd1;
  assign right_inc = (right_score == 4'd15) ? 4'd15 : right_score + 4'd1;

`ifdef MATCH_WIN_BY_TWO_EN
  assign left_win  = (left_inc == 4'd15) ||
                     ((left_inc >= WIN_4) && ({1'b0, left_inc} >= {1'b0, right_score} + 5'd2));
  assign right_win = (right_inc == 4'd15) ||
                     ((right_inc >= WIN_4) && ({1'b0, right_inc} >= {1'b0, left_score} + 5'd2));
`else
  assign left_win  = (left_inc == WIN_4);
  assign right_win = (right_inc == WIN_4);
`endif

  always_comb begin
    nxt_state  = cur_state;
    nxt_cnt    = serve_cnt;
    nxt_left   = left_score;
    nxt_right  = right_score;
    nxt_dir    = serve_dir;
    nxt_winner = winner;
    case (cur_state)
      QI: begin
        nxt_cnt    = 8'd0;
        nxt_left   = 4'd0;
        nxt_right  = 4'd0;
        nxt_winner = 1'b0;
        if (start_rise)
          nxt_state = QGAME_1;
      end
      QGAME_1: begin
        if (start_low) begin
          nxt_state  = QI;
          nxt_cnt    = 8'd0;
          nxt_left   = 4'd0;
          nxt_right  = 4'd0;
          nxt_winner = 1'b0;
        end else if (tick) begin
          if (serve_cnt == SERVE_LAST) begin
            nxt_cnt   = 8'd0;
            nxt_state = QGAME_2;
          end else begin
            nxt_cnt = serve_cnt + 8'd1;
          end
        end
      end
      QGAME_2: begin
        // Abort outranks any point arriving in the same cycle.
        if (start_low) begin
          nxt_state  = QI;
          nxt_cnt    = 8'd0;
          nxt_left   = 4'd0;
          nxt_right  = 4'd0;
          nxt_winner = 1'b0;
        end else if (point_left && point_right) begin
          nxt_state = QGAME_1;
        end else if (point_left) begin
          nxt_left = left_inc;
          nxt_dir  = 1'b1;
          if (left_win) begin
            nxt_state  = QDONE;
            nxt_winner = 1'b0;
          end else begin
            nxt_state = QGAME_1;
          end
        end else if (point_right) begin
          nxt_right = right_inc;
          nxt_dir   = 1'b0;
          if (right_win) begin
            nxt_state  = QDONE;
            nxt_winner = 1'b1;
          end else begin
            nxt_state = QGAME_1;
          end
        end
      end
      QDONE: begin
        if (start_low) begin
          nxt_state  = QI;
          nxt_cnt    = 8'd0;
          nxt_left   = 4'd0;
          nxt_right  = 4'd0;
          nxt_winner = 1'b0;
        end
      end
      default: nxt_state = QI;
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      cur_state   <= QI;
      serve_cnt   <= 8'd0;
      left_score  <= 4'd0;
      right_score <= 4'd0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      ball_run    <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      serve_cnt   <= nxt_cnt;
      left_score  <= nxt_left;
      right_score <= nxt_right;
      serve_dir   <= nxt_dir;
      winner      <= nxt_winner;
      ball_run    <= (nxt_state == QGAME_2);
      game_over   <= (nxt_state == QDONE);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_match_sequencer.sv
// tb/tb_match_sequencer.sv - scoreboard bench for match_sequencer (WIN_SCORE=3, SERVE_TICKS=4)
module tb_match_sequencer;

  localparam int WIN = 3;
  localparam int SRV = 4;

  logic       board_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       point_left = 1'b0;
  logic       point_right = 1'b0;
  logic [1:0] state;
  logic [3:0] left_score, right_score;
  logic       ball_run, serve_dir, game_over, winner;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] st;
    logic [3:0] l;
    logic [3:0] r;
    logic       dir;
    logic       run;
    logic       over;
    logic       win;
  } snap_t;

  snap_t exp_q[$];

  int m_st  = 0;
  int m_l   = 0;
  int m_r   = 0;
  bit m_dir = 1'b0;
  bit m_win = 1'b0;

  match_sequencer #(.WIN_SCORE(WIN), .SERVE_TICKS(SRV)) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .point_left (point_left),
    .point_right(point_right),
    .state      (state),
    .left_score (left_score),
    .right_score(right_score),
    .ball_run   (ball_run),
    .serve_dir  (serve_dir),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 board_clk = ~board_clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  function automatic bit model_win(input int mine, input int theirs);
`ifdef MATCH_WIN_BY_TWO_EN
    return (mine == 15) || (mine >= WIN && mine - theirs >= 2);
`else
    return (theirs < 0) ? 1'b0 : (mine == WIN);
`endif
  endfunction

  task automatic push_expect();
    snap_t s;
    s.st   = 2'(m_st);
    s.l    = 4'(m_l);
    s.r    = 4'(m_r);
    s.dir  = m_dir;
    s.run  = (m_st == 2);
    s.over = (m_st == 3);
    s.win  = m_win;
    exp_q.push_back(s);
  endtask

  task automatic compare_out(input string tag);
    snap_t s;
    s = exp_q.pop_front();
    check_val({tag, ".state"}, 8'(state), 8'(s.st));
    check_val({tag, ".left"}, 8'(left_score), 8'(s.l));
    check_val({tag, ".right"}, 8'(right_score), 8'(s.r));
    check_val({tag, ".dir"}, 8'(serve_dir), 8'(s.dir));
    check_val({tag, ".run"}, 8'(ball_run), 8'(s.run));
    check_val({tag, ".over"}, 8'(game_over), 8'(s.over));
    if (s.over) check_val({tag, ".winner"}, 8'(winner), 8'(s.win));
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
    int n = 0;
    while (state !== target && n < budget) begin
      step();
      n++;
    end
    check_val(tag, 8'(state), 8'(target));
  endtask

  task automatic start_game(input string tag);
    start = 1'b1;
    step();
    check_val({tag, ".pre"}, 8'(state), 8'd0);
    wait_state(2'd1, 3, {tag, ".rise"});
    m_st = 1;
    push_expect();
    compare_out(tag);
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    wait_state(2'd0, 4, {tag, ".drop"});
    m_st  = 0;
    m_l   = 0;
    m_r   = 0;
    m_win = 1'b0;
    push_expect();
    compare_out(tag);
  endtask

  task automatic serve(input string tag);
    for (int i = 0; i < SRV; i++) begin
      repeat (7) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (i == SRV - 2) begin
        push_expect();
        compare_out({tag, ".mid"});
      end
    end
    m_st = 2;
    push_expect();
    compare_out(tag);
  endtask

  task automatic score(input bit l, input bit r, input string tag);
    point_left  = l;
    point_right = r;
    step();
    point_left  = 1'b0;
    point_right = 1'b0;
    if (m_st == 2) begin
      if (l && r) begin
        m_st = 1;
      end else if (l) begin
        m_l   = (m_l < 15) ? m_l + 1 : 15;
        m_dir = 1'b1;
        if (model_win(m_l, m_r)) begin
          m_st  = 3;
          m_win = 1'b0;
        end else m_st = 1;
      end else if (r) begin
        m_r   = (m_r < 15) ? m_r + 1 : 15;
        m_dir = 1'b0;
        if (model_win(m_r, m_l)) begin
          m_st  = 3;
          m_win = 1'b1;
        end else m_st = 1;
      end
    end
    push_expect();
    compare_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    bit seq_l[6];
    seq_l = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    repeat (2) step();
    push_expect();
    compare_out("reset");
    reset = 1'b0;
    repeat (4) step();

    // Match A: left wins straight, with a replay in between
    start_game("a_start");
    serve("a_srv1");
    score(1'b1, 1'b0, "a_l1");
    serve("a_srv2");
    score(1'b1, 1'b1, "a_both");
    serve("a_srv3");
    score(1'b1, 1'b0, "a_l2");
    serve("a_srv4");
    score(1'b1, 1'b0, "a_l3");
    score(1'b0, 1'b1, "a_ign_done");
    drop_start("a_end");

    // Match B: abort mid-rally at 1-1
    start_game("b_start");
    serve("b_srv1");
    score(1'b1, 1'b0, "b_l1");
    serve("b_srv2");
    score(1'b0, 1'b1, "b_r1");
    serve("b_srv3");
    drop_start("b_abort");

    // Match C: 2-2 then right runs away; outcome depends on the win rule
    start_game("c_start");
    for (int i = 0; i < 6; i++) begin
      if (m_st != 3) begin
        serve("c_srv");
        score(seq_l[i], ~seq_l[i], "c_pt");
      end
    end
    check_val("c_over", 8'(game_over), 8'd1);
    drop_start("c_end");

    // Reset mid-rally with a point pending, start held high through release
    start_game("d_start");
    serve("d_srv");
    point_left = 1'b1;
    reset = 1'b1;
    #1;
    m_st  = 0;
    m_l   = 0;
    m_r   = 0;
    m_dir = 1'b0;
    m_win = 1'b0;
    push_expect();
    compare_out("rst_mid");
    step();
    point_left = 1'b0;
    step();
    reset = 1'b0;
    repeat (8) step();
    check_val("no_false_rise", 8'(state), 8'd0);
    score(1'b1, 1'b0, "ign_qi");
    start = 1'b0;
    repeat (4) step();
    start_game("e_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
